// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: one TX and one RX FSM sharing clk, configurable width/bit period/stop bits.
// Optional parity bit enabled by defining UART_PARITY_EN (PARITY_ODD selects odd parity).
module uart_core_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  tx,
    output logic                  tx_active,
    output logic                  done_tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  rx_frame_err,
    output logic                  rx_parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t                  tx_state, tx_next;
    logic [CNT_W-1:0]        tx_cnt;
    logic [BIT_W-1:0]        tx_idx;
    logic                    tx_stop_idx;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic                    tx_accept, tx_bit_end, tx_frame_end;
`ifdef UART_PARITY_EN
    logic                    tx_par;
`endif

    always_ff @(posedge clk) begin
        if (!rst) tx_state <= S_IDLE;
        else      tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:   if (start) tx_next = S_START;
            S_START:  if (tx_bit_end) tx_next = S_DATA;
            S_DATA: begin
                if (tx_bit_end && tx_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                    tx_next = S_PARITY;
`else
                    tx_next = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_bit_end) tx_next = S_STOP;
`endif
            S_STOP:   if (tx_frame_end) tx_next = S_IDLE;
            default:  tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_accept    = (tx_state == S_IDLE) && start;
        tx_bit_end   = (tx_cnt == CNT_LAST);
        tx_frame_end = (tx_state == S_STOP) && tx_bit_end && (tx_stop_idx == STOP_LAST);
        tx_active    = (tx_state != S_IDLE);
        tx           = 1'b1;
        case (tx_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx = tx_par;
`endif
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            done_tx     <= 1'b0;
        end else begin
            done_tx <= tx_frame_end;
            if (tx_accept) begin
                tx_cnt      <= '0;
                tx_idx      <= '0;
                tx_stop_idx <= 1'b0;
            end else if (tx_state != S_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == S_DATA) tx_idx <= tx_idx + BIT_W'(1);
                    if (tx_state == S_STOP) tx_stop_idx <= 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Payload and parity are captured once at acceptance, so later tx_data_in changes are harmless.
    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_shift <= tx_data_in;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_data_in ^ 1'(PARITY_ODD);
`endif
        end else if (tx_state == S_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // ---------------- receiver ----------------
    logic                    rx_s1, rx_s2, rx_d;
    state_t                  rx_state, rx_next;
    logic [CNT_W-1:0]        rx_cnt;
    logic [BIT_W-1:0]        rx_idx;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic                    rx_fall, rx_mid, rx_finish;
`ifdef UART_PARITY_EN
    logic                    rx_par_bit;
`endif

    // rx_d is one extra stage so a falling edge is seen on synchronised samples only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) rx_state <= S_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_next = S_START;
            S_START:  if (rx_mid) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA: begin
                if (rx_mid && rx_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                    rx_next = S_PARITY;
`else
                    rx_next = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_mid) rx_next = S_STOP;
`endif
            S_STOP:   if (rx_mid) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_fall   = rx_d && !rx_s2;
        rx_mid    = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == CNT_LAST);
        rx_finish = (rx_state == S_STOP) && rx_mid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_data_out  <= '0;
        end else begin
            rx_valid     <= rx_finish;
            rx_frame_err <= rx_finish && !rx_s2;
            if (rx_finish) rx_data_out <= rx_shift;
            if (rx_state == S_IDLE) begin
                rx_cnt <= '0;
                rx_idx <= '0;
            end else if (rx_mid) begin
                rx_cnt <= '0;
                if (rx_state == S_DATA) rx_idx <= rx_idx + BIT_W'(1);
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_mid) rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
`ifdef UART_PARITY_EN
        if (rx_state == S_PARITY && rx_mid) rx_par_bit <= rx_s2;
`endif
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) rx_parity_err <= 1'b0;
        else      rx_parity_err <= rx_finish && (rx_par_bit != (^rx_shift ^ 1'(PARITY_ODD)));
    end
`else
    assign rx_parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Randomised self-checking bench for uart_core_param: TX waveform model, RX word scoreboard, loopback.
// Frame bits are derived from the serial frame format, independent of the RTL's FSM.
module tb_uart_core_param;

    localparam int CPB  = 4;
    localparam int DW   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DW + P + SB;
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_data_in = '0;
    logic          tx, tx_active, done_tx;
    logic          rx_w;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b0;
    logic [DW-1:0] rx_data_out;
    logic          rx_valid, rx_frame_err, rx_parity_err;

    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;
    logic [31:0]   got_q[$];
    logic [31:0]   exp_q[$];

    always #5 clk = ~clk;
    assign rx_w = loop_en ? tx : rx_drv;

    uart_core_param #(
        .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tx_data_in(tx_data_in),
        .tx(tx), .tx_active(tx_active), .done_tx(done_tx),
        .rx(rx_w), .rx_data_out(rx_data_out), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial value of bit slot idx in a frame: start, data LSB first, optional parity, stop(s).
    function automatic logic frame_bit(input logic [DW-1:0] d, input int idx,
                                       input logic par_v, input logic stop_v);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (P == 1 && idx == DW + 1) return par_v;
        if (idx == DW + 1 + P) return stop_v;
        return 1'b1;
    endfunction

    function automatic logic [31:0] word(input logic [DW-1:0] d, input logic fe, input logic pe);
        return {22'b0, fe, pe, d};
    endfunction

    function automatic logic good_par(input logic [DW-1:0] d);
        return ^d ^ PODD[0];
    endfunction

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(word(rx_data_out, rx_frame_err, rx_parity_err));
        if (done_tx) done_cnt++;
    end

    task automatic send_tx(input logic [DW-1:0] d, input logic inject);
        start = 1'b1;
        tx_data_in = d;
        @(negedge clk);
        start = 1'b0;
        tx_data_in = ~d;
        for (int k = 0; k < FRAME; k++) begin
            chk("tx_bit", tx, frame_bit(d, k / CPB, good_par(d), 1'b1));
            chk("tx_active", tx_active, 1);
            chk("tx_done_early", done_tx, 0);
            start = inject && (k == 2 * CPB + 1);
            if (start) tx_data_in = DW'($urandom);
            @(negedge clk);
        end
        chk("tx_done", done_tx, 1);
        chk("tx_active_fall", tx_active, 0);
        chk("tx_idle", tx, 1);
        @(negedge clk);
        chk("tx_done_pulse", done_tx, 0);
    endtask

    task automatic drive_rx(input logic [DW-1:0] d, input logic stop_v, input logic par_v);
        for (int b = 0; b < NBITS; b++) begin
            rx_drv = frame_bit(d, b, par_v, stop_v);
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(word(d, !stop_v, (P == 1) && (par_v != good_par(d))));
    endtask

    task automatic compare_rx();
        int n;
        repeat (8) @(negedge clk);
        chk("rx_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("rx_word", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_tx !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_tx, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int d0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_active", tx_active, 0);
        chk("rst_done", done_tx, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data_out, 0);

        send_tx(8'hA5, 1'b1);
        send_tx(8'h07, 1'b0);

        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = DW'($urandom);
            exp_q.push_back(word(d, 1'b0, 1'b0));
            send_tx(d, 1'b0);
        end
        compare_rx();

        // Back-to-back: start held through done_tx, second payload presented after acceptance.
        start = 1'b1;
        tx_data_in = 8'h3C;
        @(negedge clk);
        tx_data_in = 8'hC3;
        exp_q.push_back(word(8'h3C, 1'b0, 1'b0));
        exp_q.push_back(word(8'hC3, 1'b0, 1'b0));
        wait_done("b2b_done1");
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_gap", tx, 0);
        chk("b2b_active", tx_active, 1);
        wait_done("b2b_done2");
        compare_rx();
        loop_en = 1'b0;

        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        compare_rx();
        drive_rx(8'h55, 1'b1, good_par(8'h55));
        compare_rx();

        drive_rx(8'h81, 1'b0, good_par(8'h81));
        drive_rx(8'h07, 1'b1, 1'b0);
        compare_rx();

        for (int i = 0; i < 8; i++) begin
            d = DW'($urandom);
            drive_rx(d, ($urandom_range(3) != 0), 1'(($urandom_range(3) == 0) ^ good_par(d)));
        end
        compare_rx();

        // Reset while both TX and RX are mid data bits.
        d0 = done_cnt;
        start = 1'b1;
        tx_data_in = DW'($urandom);
        rx_drv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rx_drv = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_active", tx_active, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_rx_data", rx_data_out, 0);
        rx_drv = 1'b1;
        rst = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        compare_rx();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
